// File: rtl/pack_pkg.sv
// Shared types for the serial-to-parallel packer.
package pack_pkg;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_ONE,
    Q_FULL
  } q_state_t;

endpackage

// File: rtl/pack_queue.sv
// Two-entry stb/rdy skid queue: head drives the output, skid absorbs one extra push.
module pack_queue
  import pack_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_stb,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_stb,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  q_state_t state, state_nxt;
  logic [W-1:0] head, skid;
  logic push, pop;

  assign in_rdy  = (state != Q_FULL);
  assign out_stb = (state != Q_EMPTY);
  assign out_dat = head;
  assign push    = in_stb & in_rdy;
  assign pop     = out_stb & out_rdy;

  always_comb begin
    state_nxt = state;
    case (state)
      Q_EMPTY: if (push) state_nxt = Q_ONE;
      Q_ONE: begin
        if (push && !pop)      state_nxt = Q_FULL;
        else if (pop && !push) state_nxt = Q_EMPTY;
      end
      Q_FULL:  if (pop) state_nxt = Q_ONE;
      default: state_nxt = Q_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= Q_EMPTY;
    else     state <= state_nxt;
  end

  // Data registers need no reset; out_stb masks them while empty.
  always_ff @(posedge clk) begin
    case (state)
      Q_EMPTY: if (push) head <= in_dat;
      Q_ONE: begin
        if (push && pop) head <= in_dat;
        else if (push)   skid <= in_dat;
      end
      Q_FULL:  if (pop) head <= skid;
      default: ;
    endcase
  end

endmodule

// File: rtl/pack.sv
// Packs ARGD consecutive ARGW-bit words (word 0 first, into the LSBs) into one vector.
module pack #(
  parameter int unsigned ARGW = 8,
  parameter int unsigned ARGD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_stb,
  input  logic [ARGW-1:0]      arg_dat,
  output logic                 arg_rdy,
  output logic                 out_stb,
  output logic [ARGD*ARGW-1:0] out_dat,
  input  logic                 out_rdy
);

  localparam int unsigned IDXW = $clog2(ARGD);
  localparam logic [IDXW-1:0] END = IDXW'(ARGD - 1);

  logic [IDXW-1:0]            idx;
  logic [(ARGD-1)*ARGW-1:0]   asm_q;
  logic                       last, xfer, push, q_rdy;

  assign last    = (idx == END);
  assign arg_rdy = !last || q_rdy;
  assign xfer    = arg_stb && arg_rdy;
  assign push    = xfer && last;

  always_ff @(posedge clk) begin
    if (rst)       idx <= '0;
    else if (xfer) idx <= last ? '0 : idx + 1'b1;
  end

  // The final word bypasses asm_q and goes straight into the queue.
  always_ff @(posedge clk) begin
    if (xfer && !last) begin
      for (int unsigned k = 0; k < ARGD - 1; k++) begin
        if (idx == IDXW'(k)) asm_q[k*ARGW +: ARGW] <= arg_dat;
      end
    end
  end

  pack_queue #(
    .W (ARGD*ARGW)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .in_stb  (push),
    .in_dat  ({arg_dat, asm_q}),
    .in_rdy  (q_rdy),
    .out_stb (out_stb),
    .out_dat (out_dat),
    .out_rdy (out_rdy)
  );

endmodule

// File: tb/tb_pack.sv
// Self-checking bench for pack: directed table, reset cases, random traffic vs a word-queue model.
module tb_pack;

  localparam int W = 8;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst;
  logic arg_stb, arg_rdy, out_stb, out_rdy;
  logic [W-1:0]   arg_dat;
  logic [D*W-1:0] out_dat;

  logic a4_stb, a4_rdy, o4_stb, o4_rdy;
  logic [7:0]  a4_dat;
  logic [31:0] o4_dat;

  always #5 clk = ~clk;

  pack #(.ARGW(W), .ARGD(D)) dut (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
    .out_stb(out_stb), .out_dat(out_dat), .out_rdy(out_rdy)
  );

  pack #(.ARGW(8), .ARGD(4)) dut4 (
    .clk(clk), .rst(rst), .arg_stb(a4_stb), .arg_dat(a4_dat), .arg_rdy(a4_rdy),
    .out_stb(o4_stb), .out_dat(o4_dat), .out_rdy(o4_rdy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted words awaiting completion, and completed vectors not yet popped.
  logic [W-1:0]   acc[$];
  logic [D*W-1:0] expq[$];
  logic in_x = 1'b0;
  logic out_x = 1'b0;

  task automatic sample_check();
    logic e_rdy;
    @(negedge clk);
    e_rdy = !(acc.size() == D - 1 && expq.size() == 2);
    chk("arg_rdy", {63'd0, arg_rdy}, {63'd0, e_rdy});
    chk("out_stb", {63'd0, out_stb}, {63'd0, expq.size() != 0});
    if (expq.size() != 0) chk("out_dat", 64'(out_dat), 64'(expq[0]));
    in_x  = arg_stb && e_rdy;
    out_x = (expq.size() != 0) && out_rdy;
  endtask

  task automatic advance();
    logic [D*W-1:0] v;
    @(posedge clk);
    #1;
    if (rst) begin
      acc.delete();
      expq.delete();
    end else begin
      if (out_x) void'(expq.pop_front());
      if (in_x) begin
        acc.push_back(arg_dat);
        if (acc.size() == D) begin
          v = '0;
          for (int k = 0; k < D; k++) v[k*W +: W] = acc[k];
          expq.push_back(v);
          acc.delete();
        end
      end
    end
  endtask

  task automatic tick();
    sample_check();
    advance();
  endtask

  typedef struct {
    logic           stb;
    logic [W-1:0]   dat;
    logic           ordy;
    logic           rdy;
    logic           ostb;
    logic [D*W-1:0] odat;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Basic packing
    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h2211};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000};
    // Backpressure: A6 stalls until the consumer drains one vector
    tbl[4]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[6]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 16'hA2A1};
    tbl[7]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 16'hA2A1};
    tbl[8]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 16'hA2A1};
    tbl[9]  = '{1'b1, 8'hA6, 1'b0, 1'b0, 1'b1, 16'hA2A1};
    tbl[10] = '{1'b1, 8'hA6, 1'b1, 1'b0, 1'b1, 16'hA2A1};
    tbl[11] = '{1'b1, 8'hA6, 1'b1, 1'b1, 1'b1, 16'hA4A3};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'hA6A5};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000};

    rst = 1'b1; arg_stb = 1'b0; arg_dat = '0; out_rdy = 1'b0;
    a4_stb = 1'b0; a4_dat = '0; o4_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_o4_stb", {63'd0, o4_stb}, 64'd0);
    chk("rst_a4_rdy", {63'd0, a4_rdy}, 64'd1);

    foreach (tbl[i]) begin
      arg_stb = tbl[i].stb; arg_dat = tbl[i].dat; out_rdy = tbl[i].ordy;
      sample_check();
      chk($sformatf("tbl%0d_rdy", i), {63'd0, arg_rdy}, {63'd0, tbl[i].rdy});
      chk($sformatf("tbl%0d_stb", i), {63'd0, out_stb}, {63'd0, tbl[i].ostb});
      if (tbl[i].ostb) chk($sformatf("tbl%0d_dat", i), 64'(out_dat), 64'(tbl[i].odat));
      advance();
    end

    // Streaming 0x01..0x08 with the consumer always ready
    out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      arg_stb = 1'b1; arg_dat = W'(i);
      tick();
    end
    arg_stb = 1'b0;
    tick();
    tick();

    // Reset mid-vector discards the partial word
    arg_stb = 1'b1; arg_dat = 8'h55;
    tick();
    arg_stb = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    arg_stb = 1'b1; arg_dat = 8'h66;
    tick();
    arg_dat = 8'h77;
    tick();
    arg_stb = 1'b0;
    sample_check();
    chk("rstmid_stb", {63'd0, out_stb}, 64'd1);
    chk("rstmid_dat", 64'(out_dat), 64'h7766);
    advance();
    tick();

    // Random traffic with occasional resets; producer holds data until accepted
    for (int i = 0; i < 600; i++) begin
      if (!arg_stb || in_x || rst) begin
        arg_stb = ($urandom_range(0, 3) != 0);
        arg_dat = W'($urandom);
      end
      out_rdy = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; arg_stb = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drained", {63'd0, out_stb}, 64'd0);

    // ARGD=4 instance: gappy producer, random consumer, single vector 0x0A0B0C0D
    begin
      logic [7:0] w4[4];
      int wi, pops;
      logic xf, ps, pr;
      logic [31:0] pd;
      w4[0] = 8'h0D; w4[1] = 8'h0C; w4[2] = 8'h0B; w4[3] = 8'h0A;
      wi = 0; pops = 0; xf = 1'b0; ps = 1'b0; pr = 1'b0; pd = '0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (xf) wi++;
        if (ps && !pr) begin
          chk("a4_hold_stb", {63'd0, o4_stb}, 64'd1);
          chk("a4_hold_dat", 64'(o4_dat), 64'(pd));
        end
        if (o4_stb && o4_rdy) begin
          chk("a4_vec", 64'(o4_dat), 64'h0A0B0C0D);
          pops++;
        end
        if (wi < 4) chk("a4_rdy", {63'd0, a4_rdy}, 64'd1);
        a4_stb = (wi < 4) && ($urandom_range(0, 2) != 0);
        a4_dat = (wi < 4) ? w4[wi] : 8'h00;
        o4_rdy = ($urandom_range(0, 1) == 0) || (c > 60);
        xf = a4_stb && a4_rdy;
        ps = o4_stb; pr = o4_rdy; pd = o4_dat;
      end
      chk("a4_words", 64'(wi), 64'd4);
      chk("a4_pops", 64'(pops), 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
